psum_accum_ctrl: RTL and testbench

PSUM_ACCUM_CTRL -- requirements
Module: psum_accum_ctrl

---
 rtl/psum_accum_ctrl_if.sv | 41 ++++
 rtl/psum_accum_ctrl.sv | 154 +++++++++++++++
 tb/tb_psum_accum_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_ctrl_if.sv
// Product, scratchpad and drain buses of the partial-sum accumulator.
// The slave modport is the controller's view; master is the surrounding datapath.
interface psum_accum_ctrl_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);
    logic              prod_valid;
    logic              prod_ready;
    logic [DATA_W-1:0] prod_data;
    logic [ADDR_W-1:0] prod_addr;
    logic              prod_first;
    logic              prod_last;

    logic              spad_rd;
    logic              spad_wr;
    logic [ADDR_W-1:0] spad_addr;
    logic [DATA_W-1:0] spad_wdata;
    logic [DATA_W-1:0] spad_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  prod_valid, prod_data, prod_addr, prod_first, prod_last,
        output prod_ready,
        output spad_rd, spad_wr, spad_addr, spad_wdata,
        input  spad_rdata,
        output out_valid, out_data,
        input  out_ready
    );

    modport master (
        output prod_valid, prod_data, prod_addr, prod_first, prod_last,
        input  prod_ready,
        input  spad_rd, spad_wr, spad_addr, spad_wdata,
        output spad_rdata,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulation controller: read-modify-write of products into a
// scratchpad with saturating add, then drains entries 0..num_psum in order.
module psum_accum_ctrl #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_psum,
    psum_accum_ctrl_if.slave  bus,
    output logic              busy,
    output logic              done,
    output logic              sat
);

    typedef enum logic [2:0] {IDLE, ACC, WB, DRD, DOUT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              sat_q, sat_d;
    logic              done_q, done_d;
    logic              rdv_q, rdv_d;
    logic [DATA_W:0]   sum_c;
    logic [DATA_W-1:0] acc_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            odata_q <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            odata_q <= odata_d;
            first_q <= first_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
            rdv_q   <= rdv_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        idx_d          = idx_q;
        addr_d         = addr_q;
        data_d         = data_q;
        first_d        = first_q;
        last_d         = last_q;
        sat_d          = sat_q;
        done_d         = 1'b0;
        rdv_d          = 1'b0;
        bus.prod_ready = 1'b0;
        bus.spad_rd    = 1'b0;
        bus.spad_wr    = 1'b0;
        bus.spad_addr  = '0;
        bus.spad_wdata = '0;

        sum_c   = {1'b0, bus.spad_rdata} + {1'b0, data_q};
        acc_c   = sum_c[DATA_W] ? {DATA_W{1'b1}} : sum_c[DATA_W-1:0];
        // Scratchpad read data is only valid in the first DOUT cycle; keep a copy.
        odata_d = rdv_q ? bus.spad_rdata : odata_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = num_psum;
                    sat_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                bus.prod_ready = 1'b1;
                if (bus.prod_valid) begin
                    data_d  = bus.prod_data;
                    addr_d  = bus.prod_addr;
                    first_d = bus.prod_first;
                    last_d  = bus.prod_last;
                    state_d = WB;
                    if (!bus.prod_first) begin
                        bus.spad_rd   = 1'b1;
                        bus.spad_addr = bus.prod_addr;
                    end
                end
            end
            WB: begin
                bus.spad_wr    = 1'b1;
                bus.spad_addr  = addr_q;
                bus.spad_wdata = first_q ? data_q : acc_c;
                if (!first_q && sum_c[DATA_W]) sat_d = 1'b1;
                if (last_q) begin
                    idx_d   = '0;
                    state_d = DRD;
                end else begin
                    state_d = ACC;
                end
            end
            DRD: begin
                bus.spad_rd   = 1'b1;
                bus.spad_addr = idx_q;
                rdv_d         = 1'b1;
                state_d       = DOUT;
            end
            DOUT: begin
                if (bus.out_ready) begin
                    if (idx_q == num_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = DRD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset wins over any handshake or scratchpad access in the same cycle.
        if (rst) begin
            bus.prod_ready = 1'b0;
            bus.spad_rd    = 1'b0;
            bus.spad_wr    = 1'b0;
            bus.spad_addr  = '0;
            bus.spad_wdata = '0;
        end
    end

    assign bus.out_valid = (state_q == DOUT);
    assign bus.out_data  = rdv_q ? bus.spad_rdata : odata_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign sat           = sat_q;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench for psum_accum_ctrl with a scratchpad model and an output scoreboard.
module tb_psum_accum_ctrl;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] num_psum;
    logic              busy, done, sat;

    psum_accum_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    psum_accum_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_psum (num_psum),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    // Scratchpad: write priority, read data registered
    logic [DATA_W-1:0] mem [0:63];
    always @(posedge clk) begin
        if (bus.spad_wr)      mem[bus.spad_addr] <= bus.spad_wdata;
        else if (bus.spad_rd) bus.spad_rdata     <= mem[bus.spad_addr];
    end

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every drain handshake
    initial begin
        bit   exp_done_next;
        bit   exp_done;
        exp_t it;
        exp_done_next = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            exp_done      = exp_done_next;
            exp_done_next = 1'b0;
            if (!rst) begin
                if (done || exp_done) check("done_pulse", done, exp_done);
                if (bus.spad_rd || bus.spad_wr)
                    check("rd_wr_exclusive", bus.spad_rd & bus.spad_wr, 0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", exp_q.size(), 1);
                    end else begin
                        it = exp_q.pop_front();
                        check("out_data", bus.out_data, it.data);
                        check("sat_at_drain", sat, it.sat);
                        if (it.last) exp_done_next = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push(input logic [DATA_W-1:0] d, input logic l, input logic s);
        exp_t e;
        e.data = d; e.last = l; e.sat = s;
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_prod_ready"}, bus.prod_ready, 0);
        check({tag, "_spad_rd"},    bus.spad_rd, 0);
        check({tag, "_spad_wr"},    bus.spad_wr, 0);
        check({tag, "_spad_addr"},  bus.spad_addr, 0);
        check({tag, "_spad_wdata"}, bus.spad_wdata, 0);
        check({tag, "_out_valid"},  bus.out_valid, 0);
        check({tag, "_out_data"},   bus.out_data, 0);
        check({tag, "_done"},       done, 0);
        check({tag, "_sat"},        sat, 0);
    endtask

    task automatic start_pass(input logic [ADDR_W-1:0] n);
        start    = 1'b1;
        num_psum = n;
        @(negedge clk); #1;
        start    = 1'b0;
        num_psum = 6'd63;
        check("busy_after_start", busy, 1);
        check("sat_cleared_by_start", sat, 0);
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic f, input logic l, input logic hold, output int waits);
        bus.prod_valid = 1'b1;
        bus.prod_addr  = a;
        bus.prod_data  = d;
        bus.prod_first = f;
        bus.prod_last  = l;
        waits = 0;
        #1;
        while (!bus.prod_ready && waits < 50) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!bus.prod_ready) begin
            check("prod_ready_timeout", bus.prod_ready, 1);
            bus.prod_valid = 1'b0;
            return;
        end
        check("accept_spad_rd", bus.spad_rd, !f);
        if (!f) check("accept_spad_addr", bus.spad_addr, a);
        @(negedge clk); #1;
        check("wb_spad_wr", bus.spad_wr, 1);
        check("wb_spad_rd", bus.spad_rd, 0);
        check("wb_spad_addr", bus.spad_addr, a);
        check("wb_prod_ready", bus.prod_ready, 0);
        if (!hold) bus.prod_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_complete", busy, 0);
        @(negedge clk); #1;
    endtask

    initial begin
        int w;
        logic [DATA_W-1:0] snap;
        int n;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; num_psum = '0;
        bus.prod_valid = 1'b0; bus.prod_addr = '0; bus.prod_data = '0;
        bus.prod_first = 1'b0; bus.prod_last = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk); #1;

        // Two entries accumulated to 8 and 10
        start_pass(1);
        push(8, 0, 0); push(10, 1, 0);
        send(0, 3, 1, 0, 0, w);
        send(1, 4, 1, 0, 0, w);
        send(0, 5, 0, 0, 0, w);
        send(1, 6, 0, 1, 0, w);
        wait_idle();

        // 200 + 100 saturates; entries 0/1 drain their old contents
        start_pass(2);
        push(8, 0, 1); push(10, 0, 1); push(255, 1, 1);
        send(2, 200, 1, 0, 0, w);
        send(2, 100, 0, 1, 0, w);
        wait_idle();
        check("sat_sticky_in_idle", sat, 1);

        // Drain back-pressure for 5 cycles
        bus.out_ready = 1'b0;
        start_pass(1);
        push(7, 0, 0); push(9, 1, 0);
        send(0, 7, 1, 0, 0, w);
        send(1, 9, 1, 1, 0, w);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("stall_out_valid_seen", bus.out_valid, 1);
        snap = bus.out_data;
        check("stall_first_data", snap, 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_data", bus.out_data, snap);
            check("stall_no_spad_rd", bus.spad_rd, 0);
        end
        bus.out_ready = 1'b1;
        wait_idle();

        // prod_valid held high: ready alternates ACC/WB
        start_pass(3);
        push(6, 0, 0); push(2, 0, 0); push(3, 0, 0); push(10, 1, 0);
        send(0, 1, 1, 0, 1, w);
        send(1, 2, 1, 0, 1, w); check("ready_alternate", w, 1);
        send(2, 3, 1, 0, 1, w); check("ready_alternate", w, 1);
        send(3, 4, 1, 0, 1, w); check("ready_alternate", w, 1);
        send(0, 5, 0, 0, 1, w); check("ready_alternate", w, 1);
        send(3, 6, 0, 1, 0, w); check("ready_alternate", w, 1);
        wait_idle();

        // start in ACC ignored; num_psum=0 drains one entry
        start_pass(0);
        start = 1'b1; num_psum = 6'd5;
        @(negedge clk); #1;
        start = 1'b0;
        check("start_in_acc_ready", bus.prod_ready, 1);
        push(42, 1, 0);
        send(0, 42, 1, 1, 0, w);
        wait_idle();

        // Reset during WB suppresses the write
        start_pass(0);
        send(5, 99, 1, 0, 0, w);
        rst = 1'b1;
        #1;
        check("rst_wb_no_write", bus.spad_wr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("post_rst");
        check("rst_mem_untouched", mem[5], 0);
        @(negedge clk); #1;
        start_pass(0);
        push(11, 1, 0);
        send(0, 11, 1, 1, 0, w);
        wait_idle();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
